// File: rtl/hms_pkg.sv
// Shared encodings and constants for the HH:MM:SS multiplexed 7-segment scanner.
package hms_pkg;

  typedef enum logic [1:0] {
    EditNone = 2'b00,
    EditHrs  = 2'b01,
    EditMin  = 2'b10,
    EditSec  = 2'b11
  } edit_field_e;

  // Segment order {g,f,e,d,c,b,a}
  localparam logic [6:0] SegCodes [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SegDash  = 7'h40;
  localparam logic [6:0] SegBlank = 7'h00;

  // BCD value the decoder maps to a dash
  localparam logic [3:0] BcdDash = 4'hA;

  localparam logic [2:0] IdxSecU = 3'd0;
  localparam logic [2:0] IdxSecT = 3'd1;
  localparam logic [2:0] IdxMinU = 3'd2;
  localparam logic [2:0] IdxMinT = 3'd3;
  localparam logic [2:0] IdxHrsU = 3'd4;
  localparam logic [2:0] IdxHrsT = 3'd5;

  localparam logic [4:0] HrsMax    = 5'd23;
  localparam logic [5:0] MinSecMax = 6'd59;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

  // Compare/subtract split, valid for 0..59
  function automatic bcd_pair_t split_bcd(input logic [5:0] v);
    bcd_pair_t p;
    if (v >= 6'd50) begin
      p.tens  = 4'd5;
      p.units = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      p.tens  = 4'd4;
      p.units = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      p.tens  = 4'd3;
      p.units = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      p.tens  = 4'd2;
      p.units = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      p.tens  = 4'd1;
      p.units = 4'(v - 6'd10);
    end else begin
      p.tens  = 4'd0;
      p.units = v[3:0];
    end
    return p;
  endfunction

endpackage

// File: rtl/hms_seg7.sv
// BCD to 7-segment decoder; BcdDash gives a dash, other non-decimal codes blank.
module hms_seg7
  import hms_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    if (bcd_i < 4'd10) begin
      seg_o = SegCodes[bcd_i];
    end else if (bcd_i == BcdDash) begin
      seg_o = SegDash;
    end else begin
      seg_o = SegBlank;
    end
  end

endmodule

// File: rtl/hms_display_scan.sv
// Six-digit HH:MM:SS display scanner with per-frame snapshot, anti-ghost blank
// cycle and blinking of the field being edited.
module hms_display_scan
  import hms_pkg::*;
#(
  parameter int unsigned BLINK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_tick,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [1:0] edit_field,
  output logic [5:0] digit_en,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned FrameW = BLINK_LOG2 + 1;
  localparam logic [FrameW-1:0] FrameOne = 1;

  logic [2:0]        idx_q, idx_d;
  logic              pend_q, pend_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic [4:0]        snap_hrs_q, snap_hrs_d;
  logic [5:0]        snap_min_q, snap_min_d;
  logic [5:0]        snap_sec_q, snap_sec_d;
  edit_field_e       snap_edit_q, snap_edit_d;
  logic [5:0]        digit_en_q, digit_en_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic [5:0]  field_val;
  logic        field_bad;
  edit_field_e field_id;
  bcd_pair_t   pair;
  logic [3:0]  bcd;
  logic [6:0]  seg_code;
  logic        blink;
  logic        wrap;

  // Digit mux works on the current index, which is already the new one while pend_q is set
  always_comb begin
    case (idx_q)
      IdxSecU, IdxSecT: begin
        field_val = snap_sec_q;
        field_bad = snap_sec_q > MinSecMax;
        field_id  = EditSec;
      end
      IdxMinU, IdxMinT: begin
        field_val = snap_min_q;
        field_bad = snap_min_q > MinSecMax;
        field_id  = EditMin;
      end
      default: begin
        field_val = {1'b0, snap_hrs_q};
        field_bad = snap_hrs_q > HrsMax;
        field_id  = EditHrs;
      end
    endcase
    pair  = split_bcd(field_val);
    bcd   = field_bad ? BcdDash : (idx_q[0] ? pair.tens : pair.units);
    // field_id is never EditNone, so an idle edit_field never blanks
    blink = frame_q[FrameW-1] && (snap_edit_q == field_id);
  end

  hms_seg7 u_seg7 (
    .bcd_i(bcd),
    .seg_o(seg_code)
  );

  always_comb begin
    idx_d       = idx_q;
    pend_d      = pend_q;
    frame_d     = frame_q;
    snap_hrs_d  = snap_hrs_q;
    snap_min_d  = snap_min_q;
    snap_sec_d  = snap_sec_q;
    snap_edit_d = snap_edit_q;
    digit_en_d  = digit_en_q;
    seg_d       = seg_q;
    dp_d        = dp_q;
    wrap        = scan_tick && (idx_q == IdxHrsT);

    if (scan_tick) begin
      idx_d      = wrap ? IdxSecU : idx_q + 3'd1;
      pend_d     = 1'b1;
      digit_en_d = '0;
      seg_d      = SegBlank;
      dp_d       = 1'b0;
      if (wrap) begin
        snap_hrs_d  = hrs;
        snap_min_d  = min;
        snap_sec_d  = sec;
        snap_edit_d = edit_field_e'(edit_field);
        frame_d     = frame_q + FrameOne;
      end
    end else if (pend_q) begin
      pend_d     = 1'b0;
      digit_en_d = 6'b1 << idx_q;
      seg_d      = blink ? SegBlank : seg_code;
      dp_d       = (idx_q == IdxMinU) || (idx_q == IdxHrsU);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= IdxHrsT;
      pend_q      <= 1'b0;
      frame_q     <= '1;
      snap_hrs_q  <= '0;
      snap_min_q  <= '0;
      snap_sec_q  <= '0;
      snap_edit_q <= EditNone;
      digit_en_q  <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      frame_q     <= frame_d;
      snap_hrs_q  <= snap_hrs_d;
      snap_min_q  <= snap_min_d;
      snap_sec_q  <= snap_sec_d;
      snap_edit_q <= snap_edit_d;
      digit_en_q  <= digit_en_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign digit_en = digit_en_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_hms_display_scan.sv
// Bench for hms_display_scan: behavioural model compared every cycle, directed
// literal expectations, then randomized ticks, inputs and resets.
module tb_hms_display_scan;

  localparam int unsigned BlinkLog2 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       scan_tick = 1'b0;
  logic [4:0] hrs = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic [1:0] edit_field = '0;
  logic [5:0] digit_en;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  hms_display_scan #(
    .BLINK_LOG2(BlinkLog2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_tick (scan_tick),
    .hrs       (hrs),
    .min       (min),
    .sec       (sec),
    .edit_field(edit_field),
    .digit_en  (digit_en),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                             7'h6F};

  // Model state: current digit, ticks seen, frames completed, frame snapshot
  int m_idx = 5;
  int m_frame = -1;
  bit m_started = 1'b0;
  bit m_blank = 1'b0;
  int m_hrs = 0, m_min = 0, m_sec = 0, m_edit = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx     <= 5;
      m_frame   <= -1;
      m_started <= 1'b0;
      m_blank   <= 1'b0;
      m_hrs     <= 0;
      m_min     <= 0;
      m_sec     <= 0;
      m_edit    <= 0;
    end else if (scan_tick) begin
      m_started <= 1'b1;
      m_blank   <= 1'b1;
      m_idx     <= (m_idx == 5) ? 0 : m_idx + 1;
      if (m_idx == 5) begin
        m_hrs   <= int'(hrs);
        m_min   <= int'(min);
        m_sec   <= int'(sec);
        m_edit  <= int'(edit_field);
        m_frame <= m_frame + 1;
      end
    end else begin
      m_blank <= 1'b0;
    end
  end

  logic [5:0] e_de;
  logic [6:0] e_sg;
  logic       e_dp;

  always @(negedge clk) begin
    int field, val, lim, digit;
    e_de = '0;
    e_sg = '0;
    e_dp = 1'b0;
    if (m_started && !m_blank) begin
      e_de  = 6'(1 << m_idx);
      field = m_idx / 2;  // 0 sec, 1 min, 2 hrs
      val   = (field == 0) ? m_sec : (field == 1) ? m_min : m_hrs;
      lim   = (field == 2) ? 23 : 59;
      digit = (m_idx % 2 == 1) ? val / 10 : val % 10;
      e_sg  = (val > lim) ? 7'h40 : codes[digit];
      if (m_edit != 0 && field == 3 - m_edit && ((m_frame >> BlinkLog2) & 1) == 1) e_sg = '0;
      e_dp = (m_idx == 2) || (m_idx == 4);
    end
    checks++;
    if (digit_en !== e_de || seg !== e_sg || dp !== e_dp) begin
      errors++;
      $display("FAIL model t=%0t: got digit_en=%b seg=%h dp=%b, want digit_en=%b seg=%h dp=%b",
               $time, digit_en, seg, dp, e_de, e_sg, e_dp);
    end
  end

  task automatic expect_out(input string name, input logic [5:0] de, input logic [6:0] sg,
                            input logic d);
    checks++;
    if (digit_en !== de || seg !== sg || dp !== d) begin
      errors++;
      $display("FAIL %s: got digit_en=%b seg=%h dp=%b, want digit_en=%b seg=%h dp=%b",
               name, digit_en, seg, dp, de, sg, d);
    end
  endtask

  // Returns at the negedge after the tick edge (blank cycle visible)
  task automatic tick();
    @(negedge clk);
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
  endtask

  // Returns with the new digit on display
  task automatic tick_show();
    tick();
    @(negedge clk);
  endtask

  logic [6:0] full_exp [6];

  initial begin
    full_exp = '{7'h7F, 7'h6D, 7'h6F, 7'h6D, 7'h4F, 7'h5B};
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("reset", 6'b0, 7'h00, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    expect_out("idle_after_release", 6'b0, 7'h00, 1'b0);

    // First tick: blank, then sec units of zero snapshot
    tick();
    expect_out("first_blank", 6'b0, 7'h00, 1'b0);
    @(negedge clk);
    expect_out("first_digit", 6'b000001, 7'h3F, 1'b0);

    // Full legal time 23:59:58
    repeat (5) tick_show();
    hrs = 5'd23; min = 6'd59; sec = 6'd58;
    for (int i = 0; i < 6; i++) begin
      tick_show();
      expect_out($sformatf("full_idx%0d", i), 6'(1 << i), full_exp[i], (i == 2) || (i == 4));
    end

    // Snapshot: sec changes mid-frame are deferred to the next frame
    hrs = 5'd0; min = 6'd0; sec = 6'd9;
    tick_show();
    expect_out("snap_idx0_09", 6'b000001, 7'h6F, 1'b0);
    tick_show();
    expect_out("snap_idx1_09", 6'b000010, 7'h3F, 1'b0);
    sec = 6'd10;
    repeat (4) tick_show();
    tick_show();
    expect_out("snap_idx0_10", 6'b000001, 7'h3F, 1'b0);
    tick_show();
    expect_out("snap_idx1_10", 6'b000010, 7'h06, 1'b0);
    repeat (4) tick_show();

    // Out-of-range minutes show dashes
    min = 6'd60; sec = 6'd7;
    tick_show();
    expect_out("oor_idx0", 6'b000001, 7'h07, 1'b0);
    tick_show();
    expect_out("oor_idx1", 6'b000010, 7'h3F, 1'b0);
    tick_show();
    expect_out("oor_idx2", 6'b000100, 7'h40, 1'b1);
    tick_show();
    expect_out("oor_idx3", 6'b001000, 7'h40, 1'b0);

    // Async reset during index 3, then blink sequence from frame 0
    #2 rst_n = 1'b0;
    #1 expect_out("async_reset", 6'b0, 7'h00, 1'b0);
    hrs = 5'd12; min = 6'd34; sec = 6'd56; edit_field = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_out("no_partial", 6'b0, 7'h00, 1'b0);
    tick();
    expect_out("restart_blank", 6'b0, 7'h00, 1'b0);
    @(negedge clk);
    expect_out("restart_idx0", 6'b000001, 7'h7D, 1'b0);
    for (int f = 0; f < 5; f++) begin
      bit hidden;
      hidden = (f == 2) || (f == 3);
      repeat (4) tick_show();
      expect_out($sformatf("blink_f%0d_idx4", f), 6'b010000, hidden ? 7'h00 : 7'h5B, 1'b1);
      tick_show();
      expect_out($sformatf("blink_f%0d_idx5", f), 6'b100000, hidden ? 7'h00 : 7'h06, 1'b0);
      tick_show();
    end

    // Randomized traffic, including back-to-back ticks and out-of-range fields
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      scan_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        hrs        = 5'($urandom_range(0, 31));
        min        = 6'($urandom_range(0, 63));
        sec        = 6'($urandom_range(0, 63));
        edit_field = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 expect_out("rand_reset", 6'b0, 7'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    scan_tick = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hms_display_scan.md
HMS_DISPLAY_SCAN -- requirements
Module: hms_display_scan

Interface
REQ-001 Parameter BLINK_LOG2, default 5; the blink phase toggles every 2^BLINK_LOG2 frames.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 scan_tick  input  1  one-clk pulse; advance to next digit.
REQ-005 hrs  input  5  binary hours from the time-keeping block; legal 0..23.
REQ-006 min  input  6  binary minutes; legal 0..59.
REQ-007 sec  input  6  binary seconds; legal 0..59.
REQ-008 edit_field  input  2  field being set: 00 none, 01 hrs, 10 min, 11 sec.
REQ-009 digit_en  output  6  one-hot, active-high digit select; bit 5 = hrs tens ... bit 0 = sec units.
REQ-010 seg  output  7  active-high segments {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  separator dot, active-high.

Function
REQ-012 Scan index (0..5) SHALL advance 5->0->1->...->5->0 on each scan_tick.
REQ-013 On a scan_tick that wraps the index to 0, hrs/min/sec/edit_field SHALL be captured into a snapshot; the whole frame displays only snapshot values (no tearing).
REQ-014 Cycle after a scan_tick edge: digit_en=0, seg=0, dp=0 (anti-ghost blank); following cycle: digit_en=one-hot(new index), seg/dp for that digit, held until the next scan_tick.
REQ-015 A scan_tick during the blank cycle SHALL be honoured: index advances again, blank extended one more cycle.
REQ-016 Each field SHALL be split into tens = value/10, units = value%10 (compare/subtract, no divider).
REQ-017 Digit codes (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
REQ-018 Field out of range (hrs>23, min>59, sec>59): both its digits SHALL show dash 40.
REQ-019 dp SHALL be 1 on indices 4 and 2 whenever those digits are enabled, else 0.
REQ-020 Frame counter, width BLINK_LOG2+1, SHALL increment on each wrap to index 0 (rolls over); blink phase = its MSB.
REQ-021 When phase=1 and snapshot edit_field selects a field, seg SHALL be 00 for that field's two digits; digit_en and dp unaffected.
REQ-022 edit_field=00 SHALL never blank.

Reset
REQ-023 rst_n low SHALL force digit_en=0, seg=0, dp=0, index=5, frame counter all-ones, snapshot=0 immediately, independent of clk.
REQ-024 After release, the first scan_tick SHALL wrap to index 0, capture snapshot, and make frame counter 0.
REQ-025 Reset mid-frame SHALL abandon the frame; no partial digit emitted after release before a scan_tick.

Structure
REQ-026 Shared package hms_pkg SHALL hold edit_field encodings, the ten digit codes, dash/blank codes, digit index constants.
REQ-027 One combinational sub-module hms_seg7 (4-bit BCD in, 7-bit code out) SHALL be instantiated once on the muxed digit.
REQ-028 Outputs SHALL be driven from flops.

Verification
REQ-029 Reset, release, one scan_tick -> next cycle all outputs 0; cycle after digit_en=000001, seg=3F, dp=0.
REQ-030 hrs=23 min=59 sec=58, 6 ticks -> indices 0..5 show 7F,6D,6F,6D,4F,5B; dp=1 only at indices 2,4.
REQ-031 sec 09->10 after index 1 shown -> rest of frame uses 09; next frame index 0=3F, index 1=06.
REQ-032 BLINK_LOG2=1, edit_field=01, hrs=12 -> indices 5,4 show 06,5B in frames 0-1, seg=00 in frames 2-3, visible at frame 4.
REQ-033 min=60, sec=7 -> indices 3,2 seg=40, dp=1 at index 2; sec digits 3F,07.
REQ-034 rst_n pulsed low during index 3 -> outputs 0 asynchronously; next tick restarts at index 0, frame 0.
